// File: rtl/pwm_servo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_servo_pkg
//  Description : Shared definitions for the servo PWM link. Holds the default
//                nominal high times per 3-bit position code (also used by the
//                PWM generator), the receive FSM state encoding and the
//                counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_servo_pkg;

  // Default link timing, in clock cycles
  localparam int unsigned C_CONF_PERIODO = 1000000;
  localparam int unsigned C_LARGURA_000  = 35000;
  localparam int unsigned C_LARGURA_001  = 45700;
  localparam int unsigned C_LARGURA_010  = 56450;
  localparam int unsigned C_LARGURA_011  = 67150;
  localparam int unsigned C_LARGURA_100  = 77850;
  localparam int unsigned C_LARGURA_101  = 88550;
  localparam int unsigned C_LARGURA_110  = 99300;
  localparam int unsigned C_LARGURA_111  = 110000;
  localparam int unsigned C_TOLERANCIA   = 5000;

  // Receive FSM states
  typedef enum logic [1:0] {
    INICIAL = 2'b00,
    ALTO    = 2'b01,
    BAIXO   = 2'b10
  } estado_t;

  // Counters must reach 2*periodo (watchdog limit) without wrapping
  function automatic int unsigned largura_contador(input int unsigned periodo);
    return $clog2(2 * periodo + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sincronizador_borda.sv
`default_nettype none
// ============================================================================
//  Module      : sincronizador_borda
//  Description : Two-flop synchronizer for an asynchronous input plus
//                single-cycle rise/fall pulses derived from the synchronized
//                level and its one-cycle-delayed copy.
//  Ports       : clock   - system clock
//                reset   - asynchronous reset, active low
//                d_in    - asynchronous input
//                sinc    - synchronized level
//                subida  - one-cycle pulse on a synchronized rising edge
//                descida - one-cycle pulse on a synchronized falling edge
//  Revision    : 1.0 - initial release
// ============================================================================
module sincronizador_borda
  import pwm_servo_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic d_in,
  output logic sinc,
  output logic subida,
  output logic descida
);

  logic       meta_q, meta_d;
  logic       sinc_q, sinc_d;
  logic       atraso_q, atraso_d;
  logic [2:0] cheio_q, cheio_d;

  always_comb begin
    meta_d   = d_in;
    sinc_d   = meta_q;
    atraso_d = sinc_q;
    cheio_d  = {cheio_q[1:0], 1'b1};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q   <= 1'b0;
      sinc_q   <= 1'b0;
      atraso_q <= 1'b0;
      cheio_q  <= 3'b000;
    end else begin
      meta_q   <= meta_d;
      sinc_q   <= sinc_d;
      atraso_q <= atraso_d;
      cheio_q  <= cheio_d;
    end
  end

  // Edges are only trusted once the whole chain holds real samples; otherwise
  // a line that is already high at reset release would look like a rising edge.
  assign sinc    = sinc_q;
  assign subida  = cheio_q[2] &  sinc_q & ~atraso_q;
  assign descida = cheio_q[2] & ~sinc_q &  atraso_q;

endmodule
`default_nettype wire

// File: rtl/decodificador_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : decodificador_pwm
//  Description : Servo PWM receive-side decoder. Measures the high time of the
//                incoming PWM, maps it to the 3-bit position code, flags
//                out-of-range pulses and loss of signal.
//  Ports       : clock, reset (async, active low), pwm_in (async)
//                posicao[2:0], valido, erro, sinal_perdido, db_pwm,
//                db_estado[1:0]
//  Options     : DECODIFICADOR_PWM_CHECA_PERIODO_EN - when defined, the
//                rising-to-rising period is also checked against conf_periodo
//                (+/- conf_periodo/8); a bad period raises erro.
//  Revision    : 1.0 - initial release
// ============================================================================
module decodificador_pwm
  import pwm_servo_pkg::*;
#(
  parameter int unsigned conf_periodo = C_CONF_PERIODO,
  parameter int unsigned largura_000  = C_LARGURA_000,
  parameter int unsigned largura_001  = C_LARGURA_001,
  parameter int unsigned largura_010  = C_LARGURA_010,
  parameter int unsigned largura_011  = C_LARGURA_011,
  parameter int unsigned largura_100  = C_LARGURA_100,
  parameter int unsigned largura_101  = C_LARGURA_101,
  parameter int unsigned largura_110  = C_LARGURA_110,
  parameter int unsigned largura_111  = C_LARGURA_111,
  parameter int unsigned tolerancia   = C_TOLERANCIA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [2:0] posicao,
  output logic       valido,
  output logic       erro,
  output logic       sinal_perdido,
  output logic       db_pwm,
  output logic [1:0] db_estado
);

  localparam int unsigned   CW          = largura_contador(conf_periodo);
  localparam logic [CW-1:0] C_UM        = CW'(1);
  localparam logic [CW-1:0] C_SATURADO  = '1;
  localparam logic [CW-1:0] C_LIMITE    = CW'(2 * conf_periodo);
  localparam logic [CW-1:0] C_LIMITE_M1 = CW'(2 * conf_periodo - 1);
  localparam int            C_MINIMO    = int'(largura_000) - int'(tolerancia);
  localparam int unsigned   C_MAXIMO    = largura_111 + tolerancia;
  // Midpoints between adjacent nominal widths; reaching one selects the upper code
  localparam int unsigned   C_LIMIAR [7] = '{
    (largura_000 + largura_001) / 2, (largura_001 + largura_010) / 2,
    (largura_010 + largura_011) / 2, (largura_011 + largura_100) / 2,
    (largura_100 + largura_101) / 2, (largura_101 + largura_110) / 2,
    (largura_110 + largura_111) / 2};

  logic          sinc, subida, descida;
  estado_t       estado_q, estado_d;
  logic [CW-1:0] alto_q, alto_d;      // high-time counter
  logic [CW-1:0] cao_q, cao_d;        // watchdog: cycles since last rising edge
  logic [CW-1:0] medida_q, medida_d;  // captured width awaiting classification
  logic          pronto_q, pronto_d;
  logic [2:0]    posicao_q, posicao_d;
  logic          valido_q, valido_d;
  logic          erro_q, erro_d;
  logic          perdido_q, perdido_d;
  logic          w_expira, w_fora, w_periodo_erro;
  logic [2:0]    w_codigo;
  logic [31:0]   w_medida32;

  sincronizador_borda u_sinc (
    .clock   (clock),
    .reset   (reset),
    .d_in    (pwm_in),
    .sinc    (sinc),
    .subida  (subida),
    .descida (descida)
  );

`ifdef DECODIFICADOR_PWM_CHECA_PERIODO_EN
  localparam int unsigned C_DESVIO = conf_periodo / 8;
  logic [CW-1:0] periodo_q, periodo_d;
  logic          periodo_chk_q, periodo_chk_d;  // period measurement is meaningful
  logic [31:0]   w_periodo32;
  assign w_periodo32    = 32'(periodo_q);
  assign w_periodo_erro = periodo_chk_q &&
                          ((w_periodo32 > conf_periodo + C_DESVIO) ||
                           (w_periodo32 < conf_periodo - C_DESVIO));
`else
  assign w_periodo_erro = 1'b0;
`endif

  assign w_medida32 = 32'(medida_q);
  assign w_fora     = (int'(w_medida32) < C_MINIMO) || (w_medida32 > C_MAXIMO);

  always_comb begin
    w_codigo = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (w_medida32 >= C_LIMIAR[k]) w_codigo = 3'(k + 1);
    end
  end

  always_comb begin
    estado_d  = estado_q;
    alto_d    = alto_q;
    medida_d  = medida_q;
    pronto_d  = 1'b0;
    perdido_d = perdido_q;
`ifdef DECODIFICADOR_PWM_CHECA_PERIODO_EN
    periodo_d     = periodo_q;
    periodo_chk_d = periodo_chk_q;
`endif

    // Watchdog; a rising edge always wins over a coincident expiry
    w_expira = !subida && (cao_q == C_LIMITE_M1);
    if (subida) begin
      cao_d     = '0;
      perdido_d = 1'b0;
    end else if (cao_q != C_LIMITE) begin
      cao_d = cao_q + C_UM;
    end else begin
      cao_d = cao_q;
    end

    // The cycle that reveals the rising edge is itself a high sample,
    // so the count restarts at one to make the result equal the high time.
    case (estado_q)
      INICIAL: begin
        if (subida) begin
          alto_d   = C_UM;
          estado_d = ALTO;
`ifdef DECODIFICADOR_PWM_CHECA_PERIODO_EN
          periodo_chk_d = 1'b0;
`endif
        end
      end
      ALTO: begin
        if (descida) begin
          medida_d = alto_q;
          pronto_d = 1'b1;
          estado_d = BAIXO;
        end else if (sinc && (alto_q != C_SATURADO)) begin
          alto_d = alto_q + C_UM;
        end
      end
      BAIXO: begin
        if (subida) begin
          alto_d   = C_UM;
          estado_d = ALTO;
`ifdef DECODIFICADOR_PWM_CHECA_PERIODO_EN
          periodo_d     = cao_q + C_UM;
          periodo_chk_d = 1'b1;
`endif
        end
      end
      default: estado_d = INICIAL;
    endcase

    if (w_expira) begin
      perdido_d = 1'b1;
      estado_d  = INICIAL;
      pronto_d  = 1'b0;
`ifdef DECODIFICADOR_PWM_CHECA_PERIODO_EN
      periodo_chk_d = 1'b0;
`endif
    end

    // Output stage: one cycle after the capture, so results land three
    // cycles after the first low sample.
    valido_d  = pronto_q;
    posicao_d = posicao_q;
    erro_d    = erro_q;
    if (pronto_q) begin
      erro_d = w_fora || w_periodo_erro;
      if (!(w_fora || w_periodo_erro)) posicao_d = w_codigo;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      alto_q    <= '0;
      cao_q     <= '0;
      medida_q  <= '0;
      pronto_q  <= 1'b0;
      posicao_q <= 3'b000;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
      perdido_q <= 1'b0;
`ifdef DECODIFICADOR_PWM_CHECA_PERIODO_EN
      periodo_q     <= '0;
      periodo_chk_q <= 1'b0;
`endif
    end else begin
      estado_q  <= estado_d;
      alto_q    <= alto_d;
      cao_q     <= cao_d;
      medida_q  <= medida_d;
      pronto_q  <= pronto_d;
      posicao_q <= posicao_d;
      valido_q  <= valido_d;
      erro_q    <= erro_d;
      perdido_q <= perdido_d;
`ifdef DECODIFICADOR_PWM_CHECA_PERIODO_EN
      periodo_q     <= periodo_d;
      periodo_chk_q <= periodo_chk_d;
`endif
    end
  end

  assign posicao       = posicao_q;
  assign valido        = valido_q;
  assign erro          = erro_q;
  assign sinal_perdido = perdido_q;
  assign db_pwm        = sinc;
  assign db_estado     = estado_q;

endmodule
`default_nettype wire
